// File: rtl/bus_datapath.sv
// Single-bus 32-bit CPU datapath: register file, special registers, ALU and a
// priority bus multiplexer, all sequenced by an external control unit.
module bus_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      enable,
  input  logic [31:0]      busSelect,
  input  logic [WIDTH-1:0] inPort,
  input  logic [WIDTH-1:0] MDataIn,
  input  logic             MD_Read,
  input  logic [3:0]       Control_Signals,
  output logic [WIDTH-1:0] busMuxOut
);

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] r [16];
  logic [WIDTH-1:0] hi, lo, zhi, zlo, pc, mdr, mar, ir, y, out_reg, in_reg;

  logic [WIDTH-1:0]   alu_hi, alu_lo;
  logic [WIDTH-1:0]   src [24];
  logic [WIDTH-1:0]   a, b;
  logic [SW-1:0]      sh;
  logic [2*WIDTH-1:0] dbl_r, dbl_l, prod;
  logic               found;
  logic               unused_bits;

  assign unused_bits = ^{enable[31:26], busSelect[31:24], mar, out_reg, ir[WIDTH-1:19]};

  // Bus sources in select-bit order; C is IR[18:0] sign-extended.
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) src[i] = r[i];
    src[16] = hi;
    src[17] = lo;
    src[18] = zhi;
    src[19] = zlo;
    src[20] = pc;
    src[21] = mdr;
    src[22] = in_reg;
    src[23] = {{(WIDTH-19){ir[18]}}, ir[18:0]};
  end

  always_comb begin
    busMuxOut = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < 24; i++) begin
      if (!found && busSelect[i[4:0]]) begin
        busMuxOut = src[i[4:0]];
        found     = 1'b1;
      end
    end
  end

  assign a  = y;
  assign b  = busMuxOut;
  assign sh = b[SW-1:0];
  // Rotates taken from a doubled word; a zero amount naturally yields A.
  assign dbl_r = {a, a} >> sh;
  assign dbl_l = {a, a} << sh;
  assign prod  = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};

  always_comb begin
    alu_hi = '0;
    alu_lo = '0;
    case (Control_Signals)
      4'b0000: alu_lo = a + b;
      4'b0001: alu_lo = a - b;
      4'b0010: alu_lo = a & b;
      4'b0011: alu_lo = a | b;
      4'b0100: alu_lo = a >> sh;
      4'b0101: alu_lo = $signed(a) >>> sh;
      4'b0110: alu_lo = a << sh;
      4'b0111: alu_lo = dbl_r[WIDTH-1:0];
      4'b1000: alu_lo = dbl_l[2*WIDTH-1:WIDTH];
      4'b1001: begin
        alu_hi = prod[2*WIDTH-1:WIDTH];
        alu_lo = prod[WIDTH-1:0];
      end
      4'b1010: begin
        if (b == '0) begin
          alu_hi = a;
        end else begin
          alu_lo = $signed(a) / $signed(b);
          alu_hi = $signed(a) % $signed(b);
        end
      end
      4'b1011: alu_lo = -b;
      4'b1100: alu_lo = ~b;
      4'b1101: alu_lo = b + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < 16; i++) r[i] <= '0;
      hi      <= '0;
      lo      <= '0;
      zhi     <= '0;
      zlo     <= '0;
      pc      <= '0;
      mdr     <= '0;
      mar     <= '0;
      ir      <= '0;
      y       <= '0;
      out_reg <= '0;
      in_reg  <= '0;
    end else begin
      for (int unsigned i = 0; i < 16; i++)
        if (enable[i[4:0]]) r[i[3:0]] <= busMuxOut;
      if (enable[16]) hi <= busMuxOut;
      if (enable[17]) lo <= busMuxOut;
      if (enable[18]) begin
        zhi <= alu_hi;
        zlo <= alu_lo;
      end
      if (enable[19]) pc      <= busMuxOut;
      if (enable[20]) mdr     <= MD_Read ? MDataIn : busMuxOut;
      if (enable[21]) mar     <= busMuxOut;
      if (enable[22]) ir      <= busMuxOut;
      if (enable[23]) y       <= busMuxOut;
      if (enable[24]) out_reg <= busMuxOut;
      if (enable[25]) in_reg  <= inPort;
    end
  end

endmodule

// File: tb/tb_bus_datapath.sv
// Scoreboard bench for bus_datapath: directed program steps plus random traffic,
// checked against an instruction-level model of the datapath registers.
module tb_bus_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] enable, busSelect, inPort, MDataIn;
  logic        MD_Read;
  logic [3:0]  Control_Signals;
  logic [31:0] busMuxOut;

  bus_datapath #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .enable(enable), .busSelect(busSelect),
    .inPort(inPort), .MDataIn(MDataIn), .MD_Read(MD_Read),
    .Control_Signals(Control_Signals), .busMuxOut(busMuxOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int passes = 0;

  // Architectural state as seen by the programmer.
  logic [31:0] rf [16];
  logic [31:0] hi, lo, zh, zl, pc, mdr, mar, ir, y, outp, inpr;

  function automatic logic [31:0] bitv(input int n);
    return 32'h1 << n;
  endfunction

  function automatic logic [31:0] source(input int i);
    if (i < 16) return rf[i];
    case (i)
      16: return hi;
      17: return lo;
      18: return zh;
      19: return zl;
      20: return pc;
      21: return mdr;
      22: return inpr;
      default: return {{13{ir[18]}}, ir[18:0]};
    endcase
  endfunction

  function automatic logic [31:0] model_bus(input logic [31:0] sel);
    for (int i = 0; i < 24; i++)
      if (sel[i]) return source(i);
    return 32'h0;
  endfunction

  function automatic logic [63:0] model_alu(input logic [3:0] op, input logic [31:0] av,
                                            input logic [31:0] bv);
    int unsigned s;
    longint      p;
    int          qa, qb;
    s = 32'(bv[4:0]);
    case (op)
      4'd0:  return {32'h0, av + bv};
      4'd1:  return {32'h0, av - bv};
      4'd2:  return {32'h0, av & bv};
      4'd3:  return {32'h0, av | bv};
      4'd4:  return {32'h0, av >> s};
      4'd5:  return {32'h0, 32'($signed(av) >>> s)};
      4'd6:  return {32'h0, av << s};
      4'd7:  return (s == 0) ? {32'h0, av} : {32'h0, (av >> s) | (av << (32 - s))};
      4'd8:  return (s == 0) ? {32'h0, av} : {32'h0, (av << s) | (av >> (32 - s))};
      4'd9: begin
        p = longint'($signed(av)) * longint'($signed(bv));
        return 64'(p);
      end
      4'd10: begin
        if (bv == 32'h0) return {av, 32'h0};
        qa = $signed(av);
        qb = $signed(bv);
        return {32'(qa % qb), 32'(qa / qb)};
      end
      4'd11: return {32'h0, 32'h0 - bv};
      4'd12: return {32'h0, ~bv};
      4'd13: return {32'h0, bv + 32'h1};
      default: return 64'h0;
    endcase
  endfunction

  // mode 0: expect the model's bus value; 1: expect cval; 2: no check this cycle.
  task automatic step(input logic [31:0] en, input logic [31:0] sel, input logic [3:0] op,
                      input logic [31:0] mdin, input logic mdrd, input logic [31:0] inp,
                      input logic c, input int mode, input logic [31:0] cval,
                      input string name);
    logic [31:0] bv;
    logic [63:0] z;
    exp_t e;
    @(negedge clk);
    enable = en; busSelect = sel; Control_Signals = op;
    MDataIn = mdin; MD_Read = mdrd; inPort = inp; clr = c;
    bv = model_bus(sel);
    e.name = name;
    if (mode == 0) begin e.exp = bv;   q.push_back(e); end
    if (mode == 1) begin e.exp = cval; q.push_back(e); end
    z = model_alu(op, y, bv);
    if (c) begin
      for (int i = 0; i < 16; i++) rf[i] = 32'h0;
      {hi, lo, zh, zl, pc, mdr, mar, ir, y, outp, inpr} = '0;
    end else begin
      for (int i = 0; i < 16; i++) if (en[i]) rf[i] = bv;
      if (en[16]) hi = bv;
      if (en[17]) lo = bv;
      if (en[18]) {zh, zl} = z;
      if (en[19]) pc = bv;
      if (en[20]) mdr = mdrd ? mdin : bv;
      if (en[21]) mar = bv;
      if (en[22]) ir = bv;
      if (en[23]) y = bv;
      if (en[24]) outp = bv;
      if (en[25]) inpr = inp;
    end
  endtask

  task automatic chk(input logic [31:0] sel, input logic [31:0] exp, input string name);
    step(32'h0, sel, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1, exp, name);
  endtask

  task automatic ld(input logic [31:0] v);
    step(bitv(20), 32'h0, 4'd0, v, 1'b1, 32'h0, 1'b0, 0, 32'h0, "ld_mdr");
  endtask

  task automatic mv(input int dst, input int srcbit);
    step(bitv(dst), bitv(srcbit), 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 0, 32'h0, "move");
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] sel);
    step(bitv(18), sel, op, 32'h0, 1'b0, 32'h0, 1'b0, 0, 32'h0, "alu_op");
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (busMuxOut === e.exp) passes++;
        else $display("FAIL %s: busMuxOut=%h expected %h at %0t", e.name, busMuxOut, e.exp, $time);
      end
    end
  end

  initial begin : stim
    logic [31:0] en, sel, mdin, inp;
    logic [3:0]  op;
    logic        c;
    int          m;
    enable = '0; busSelect = '0; inPort = '0; MDataIn = '0;
    MD_Read = 1'b0; Control_Signals = '0; clr = 1'b0;

    step('1, 32'h0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b1, 2, 32'h0, "reset");
    for (int i = 0; i < 24; i++) chk(bitv(i), 32'h0, "rst_src");
    chk(32'h0, 32'h0, "rst_none");

    ld(32'h12);
    chk(bitv(21), 32'h12, "mdr_bus");
    step(bitv(2), bitv(21), 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1, 32'h12, "r2_load");
    chk(bitv(2), 32'h12, "r2_read");

    ld(32'd5); mv(19, 21);
    chk(bitv(20), 32'd5, "pc5");
    alu(4'd13, bitv(20));
    chk(bitv(19), 32'd6, "inc_zlo");
    mv(19, 19);
    chk(bitv(20), 32'd6, "pc6");

    ld(32'h8000_0012); mv(2, 21); ld(32'd4); mv(3, 21); mv(23, 2);
    alu(4'd5, bitv(3));
    chk(bitv(19), 32'hF800_0001, "shra_lo");
    chk(bitv(18), 32'h0, "shra_hi");

    ld(32'hFFFF_FFFE); mv(23, 21); ld(32'd3);
    alu(4'd9, bitv(21));
    chk(bitv(18), 32'hFFFF_FFFF, "mul_hi");
    chk(bitv(19), 32'hFFFF_FFFA, "mul_lo");

    ld(32'd7); mv(23, 21); ld(32'd2);
    alu(4'd10, bitv(21));
    chk(bitv(19), 32'd3, "div_q");
    chk(bitv(18), 32'd1, "div_r");
    ld(32'd0);
    alu(4'd10, bitv(21));
    chk(bitv(19), 32'd0, "div0_lo");
    chk(bitv(18), 32'd7, "div0_hi");

    ld(32'h77); mv(7, 21);
    chk(bitv(3) | bitv(7), 32'd4, "bus_prio");
    ld(32'h0007_FFFF); mv(22, 21);
    chk(bitv(23), 32'hFFFF_FFFF, "c_signext");
    chk(32'h0, 32'h0, "bus_none");
    chk(32'hFF00_0000, 32'h0, "bus_ignored");

    step(bitv(25), 32'h0, 4'd0, 32'h0, 1'b0, 32'h0000_ABCD, 1'b0, 1, 32'h0, "inport_ld");
    chk(bitv(22), 32'h0000_ABCD, "inport");
    step(bitv(3), bitv(3), 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1, 32'd4, "self_load");
    chk(bitv(3), 32'd4, "self_hold");

    for (int n = 0; n < 1500; n++) begin
      en   = $urandom & $urandom & $urandom;
      m    = $urandom_range(0, 9);
      if (m == 0)      sel = 32'h0;
      else if (m == 1) sel = $urandom;
      else if (m == 2) sel = $urandom & 32'hFF00_0000;
      else             sel = bitv($urandom_range(0, 23));
      op   = 4'($urandom_range(0, 15));
      mdin = $urandom;
      inp  = $urandom;
      c    = ($urandom_range(0, 63) == 0);
      if (op == 4'd10 && y == 32'h8000_0000 && model_bus(sel) == 32'hFFFF_FFFF) op = 4'd0;
      step(en, sel, op, mdin, 1'($urandom_range(0, 1)), inp, c, 0, 32'h0, "random");
    end

    step(32'h0, 32'h0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 2, 32'h0, "idle");
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #5;
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bus_datapath.md
Name: bus_datapath

Overview:
- Single-bus 32-bit CPU datapath: register file R0–R15, HI, LO, Y, 64-bit Z (ZHigh/ZLow), PC, IR, MAR, MDR, InPort and OutPort registers, an ALU, and a one-hot bus multiplexer.
- An external control unit (or bench) drives it every cycle through a register-enable vector, a bus-source select vector and an ALU op code.
- The current bus value is exported for observation.

Parameters:
- WIDTH, 32, datapath word width. All vectors below assume 32.

Ports:
- clk  in  1  rising-edge clock for all registers.
- clr  in  1  synchronous active-high reset; clears every register.
- enable  in  32  per-register load enables, sampled at posedge clk.
- busSelect  in  32  one-hot bus source select.
- inPort  in  32  external input-port data.
- MDataIn  in  32  memory read data.
- MD_Read  in  1  MDR input select: 1 = MDataIn, 0 = bus.
- Control_Signals  in  4  ALU operation code.
- busMuxOut  out  32  current bus value (combinational).

Behaviour:
- enable bit map:
  - 0–15: R0–R15
  - 16: HI
  - 17: LO
  - 18: Z (ZHigh and ZLow together)
  - 19: PC
  - 20: MDR
  - 21: MAR
  - 22: IR
  - 23: Y
  - 24: OutPort
  - 25: InPort
  - 26–31: ignored.
- Register loads:
  - Every enabled register except Z, MDR and InPort loads busMuxOut at posedge clk.
  - Z loads the 64-bit ALU result.
  - MDR loads MDataIn when MD_Read=1, else busMuxOut.
  - InPort loads inPort.
- busSelect bit map:
  - 0–15: R0–R15
  - 16: HI
  - 17: LO
  - 18: ZHigh
  - 19: ZLow
  - 20: PC
  - 21: MDR
  - 22: InPort
  - 23: C = IR[18:0] sign-extended to 32 bits
  - 24–31: ignored.
- Bus select rules:
  - No valid bit set: bus = 0.
  - Several bits set: lowest-numbered set bit wins.
- busMuxOut is purely combinational from current register contents; a register loaded at posedge appears on the bus in the same cycle, after that edge.
- ALU operands: A = Y, B = busMuxOut. The result is 64-bit and is written to Z only when enable[18] is set. Op codes:
  - 0000 ADD: ZLow = A+B, ZHigh = 0 (carry discarded)
  - 0001 SUB: ZLow = A−B, ZHigh = 0
  - 0010 AND
  - 0011 OR
  - 0100 SHR: logical right, A >> B[4:0]
  - 0101 SHRA: arithmetic right, A >>> B[4:0]
  - 0110 SHL: A << B[4:0]
  - 0111 ROR: rotate right by B[4:0]
  - 1000 ROL: rotate left by B[4:0]
  - 1001 MUL: signed, {ZHigh,ZLow} = A*B
  - 1010 DIV: signed; ZLow = quotient, ZHigh = remainder (sign follows dividend); B = 0 gives ZLow = 0, ZHigh = A
  - 1011 NEG: ZLow = −B
  - 1100 NOT: ZLow = ~B
  - 1101 INC: ZLow = B+1 (PC increment)
  - 1110 and 1111: Z = 0.
- For all non-MUL/DIV ops, ZHigh = 0. Shift/rotate amount 0 returns A unchanged.
- Latency: one cycle from enable to register update. Z is readable on the bus in the cycle after the ALU op.
- clr=1 at posedge: all registers become 0, overriding any enables. busMuxOut therefore reads 0 for every select after the reset edge.
- A register that is both selected onto the bus and enabled loads its own value (no change). Y enabled while ALU is active uses the old Y value.

Test Plan:
- Reset: assert clr one cycle with all enables high → every selectable source reads 0 on busMuxOut.
- MDR load path: MDataIn=0x12, MD_Read=1, enable[20] → next cycle, busSelect[21] gives 0x12. Then enable[2] with busSelect[21] → R2 reads 0x12.
- PC increment: PC=5. busSelect[20], op 1101, enable[18] → ZLow=6. Next cycle busSelect[19], enable[19] → PC=6.
- SHRA sign: R2=0x80000012, R3=4, Y←R2. Select R3 with op 0101, enable Z → ZLow=0xF8000001, ZHigh=0.
- MUL/DIV: Y=0xFFFFFFFE (−2), bus=3. MUL → ZHigh=0xFFFFFFFF, ZLow=0xFFFFFFFA. Y=7, bus=2, DIV → ZLow=3, ZHigh=1.
- Bus priority and C: busSelect bits 3 and 7 set → bus = R3. IR=0x0007FFFF, busSelect[23] → 0xFFFFFFFF. busSelect=0 → 0.
